// File: rtl/dummy_hls_ip_job_sched_pkg.sv
// dummy_hls_ip_sched_package: shared types and defaults for the dummy HLS job scheduler.
//   job_desc_t    : descriptor stored per job (stream base addresses and lengths)
//   sched_state_t : dispatcher FSM states
//   DEF_*         : default parameter values used by the scheduler and its FIFO
package dummy_hls_ip_sched_package;

   localparam int unsigned DEF_NB_REQ = 2;
   localparam int unsigned DEF_DEPTH  = 4;
   localparam int unsigned DEF_ADDR_W = 32;
   localparam int unsigned DEF_LEN_W  = 16;

   // Descriptor storage is sized by the package widths; the top adapts its
   // ADDR_W/LEN_W ports to these fields.
   typedef struct packed {
      logic [DEF_ADDR_W-1:0] in_addr;
      logic [DEF_ADDR_W-1:0] out_addr;
      logic [DEF_LEN_W-1:0]  in_len;
      logic [DEF_LEN_W-1:0]  out_len;
   } job_desc_t;

   typedef enum logic [1:0] {
      SCHED_IDLE,
      SCHED_LAUNCH,
      SCHED_RUN,
      SCHED_DONE
   } sched_state_t;

   // Index width that stays at least one bit for single-entry ranges.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dummy_hls_ip_job_fifo.sv
// dummy_hls_ip_job_fifo: synchronous fall-through FIFO of {job_desc_t, requester tag}.
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   clear_i              : synchronous flush (wins over push/pop)
//   push_i, desc_i, tag_i: write request and entry (ignored when full)
//   pop_i                : drop the head entry (ignored when empty)
//   desc_o, tag_o        : current head entry, valid while not empty
//   full_o, empty_o      : status flags
//   count_o              : number of stored entries
module dummy_hls_ip_job_fifo
   import dummy_hls_ip_sched_package::*;
#(
   parameter int unsigned DEPTH = DEF_DEPTH,
   parameter int unsigned TAG_W = 1
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       clear_i,
   input  logic                       push_i,
   input  job_desc_t                  desc_i,
   input  logic [TAG_W-1:0]           tag_i,
   input  logic                       pop_i,
   output job_desc_t                  desc_o,
   output logic [TAG_W-1:0]           tag_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH+1);

   typedef struct packed {
      job_desc_t        desc;
      logic [TAG_W-1:0] tag;
   } entry_t;

   entry_t           mem_q [DEPTH];
   logic [PTR_W-1:0] wr_q, rd_q;
   logic [CNT_W-1:0] count_q;
   logic             push_en, pop_en;

   assign full_o  = count_q == CNT_W'(DEPTH);
   assign empty_o = count_q == '0;
   assign count_o = count_q;
   assign push_en = push_i && !full_o;
   assign pop_en  = pop_i && !empty_o;
   assign desc_o  = mem_q[rd_q].desc;
   assign tag_o   = mem_q[rd_q].tag;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else if (clear_i) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         if (push_en) wr_q <= wr_q + PTR_W'(1);
         if (pop_en) rd_q <= rd_q + PTR_W'(1);
         count_q <= count_q + CNT_W'(push_en) - CNT_W'(pop_en);
      end
   end

   // Storage needs no reset: entries are only observed while counted.
   always_ff @(posedge clk_i) begin
      if (push_en) mem_q[wr_q] <= '{desc: desc_i, tag: tag_i};
   end

endmodule

// File: rtl/dummy_hls_ip_job_sched.sv
// dummy_hls_ip_job_sched: round-robin job scheduler sharing one dummy HLS HWPE.
//   clk_i, rst_ni         : clock, asynchronous active-low reset
//   clear_i               : synchronous flush of queue, dispatcher and pointer
//   req_valid_i/ready_o   : per-requester descriptor handshake (ready one-hot or zero)
//   req_{in,out}_addr_i   : per-requester stream base addresses
//   req_{in,out}_len_i    : per-requester stream lengths
//   acc_start_o           : one-cycle start pulse to the HWPE control
//   acc_{in,out}_addr_o   : dispatched job addresses
//   acc_{in,out}_len_o    : dispatched job lengths
//   acc_done_i            : one-cycle completion pulse from the HWPE
//   evt_o                 : one-cycle completion pulse to the issuing requester
//   busy_o                : dispatcher active or jobs queued
//   occupancy_o           : queued job count
module dummy_hls_ip_job_sched
   import dummy_hls_ip_sched_package::*;
#(
   parameter int unsigned NB_REQ = DEF_NB_REQ,
   parameter int unsigned DEPTH  = DEF_DEPTH,
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned LEN_W  = DEF_LEN_W
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           clear_i,
   input  logic [NB_REQ-1:0]              req_valid_i,
   output logic [NB_REQ-1:0]              req_ready_o,
   input  logic [NB_REQ-1:0][ADDR_W-1:0]  req_in_addr_i,
   input  logic [NB_REQ-1:0][ADDR_W-1:0]  req_out_addr_i,
   input  logic [NB_REQ-1:0][LEN_W-1:0]   req_in_len_i,
   input  logic [NB_REQ-1:0][LEN_W-1:0]   req_out_len_i,
   output logic                           acc_start_o,
   output logic [ADDR_W-1:0]              acc_in_addr_o,
   output logic [ADDR_W-1:0]              acc_out_addr_o,
   output logic [LEN_W-1:0]               acc_in_len_o,
   output logic [LEN_W-1:0]               acc_out_len_o,
   input  logic                           acc_done_i,
   output logic [NB_REQ-1:0]              evt_o,
   output logic                           busy_o,
   output logic [$clog2(DEPTH+1)-1:0]     occupancy_o
);

   localparam int unsigned TAG_W = idx_w(NB_REQ);

   logic [TAG_W-1:0] rr_q, grant, idx, head_tag, tag_q;
   logic             found, accept, pop, full, empty;
   job_desc_t        push_desc, head_desc, acc_q, acc_view;
   sched_state_t     state_q, state_d;

   // Round-robin search starting at rr_q, wrapping modulo NB_REQ.
   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < NB_REQ; i++) begin
         idx = TAG_W'((int'(rr_q) + i) % NB_REQ);
         if (!found && req_valid_i[idx]) begin
            found = 1'b1;
            grant = idx;
         end
      end
   end

   // Ready uses the current full flag, so a pop in the same cycle cannot
   // free a slot early; a flush cycle accepts nothing.
   assign accept      = found && !full && !clear_i;
   assign req_ready_o = accept ? NB_REQ'(1) << grant : '0;
   assign push_desc   = '{in_addr:  DEF_ADDR_W'(req_in_addr_i[grant]),
                          out_addr: DEF_ADDR_W'(req_out_addr_i[grant]),
                          in_len:   DEF_LEN_W'(req_in_len_i[grant]),
                          out_len:  DEF_LEN_W'(req_out_len_i[grant])};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) rr_q <= '0;
      else if (clear_i) rr_q <= '0;
      else if (accept) rr_q <= TAG_W'((int'(grant) + 1) % NB_REQ);
   end

   dummy_hls_ip_job_fifo #(
      .DEPTH(DEPTH),
      .TAG_W(TAG_W)
   ) i_fifo (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clear_i(clear_i),
      .push_i (accept),
      .desc_i (push_desc),
      .tag_i  (grant),
      .pop_i  (pop),
      .desc_o (head_desc),
      .tag_o  (head_tag),
      .full_o (full),
      .empty_o(empty),
      .count_o(occupancy_o)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= SCHED_IDLE;
      else state_q <= state_d;
   end

   // Start and completion pulses are suppressed while flushing so a job
   // cleared together with the HWPE never reports back.
   always_comb begin
      state_d     = state_q;
      pop         = 1'b0;
      acc_start_o = 1'b0;
      evt_o       = '0;
      unique case (state_q)
         SCHED_IDLE: if (!empty) state_d = SCHED_LAUNCH;
         SCHED_LAUNCH: begin
            pop = 1'b1;
            if (head_desc.in_len == '0) state_d = SCHED_DONE;
            else begin
               acc_start_o = !clear_i;
               state_d     = SCHED_RUN;
            end
         end
         SCHED_RUN: if (acc_done_i) state_d = SCHED_DONE;
         SCHED_DONE: begin
            evt_o   = clear_i ? '0 : NB_REQ'(1) << tag_q;
            state_d = SCHED_IDLE;
         end
         default: state_d = SCHED_IDLE;
      endcase
      if (clear_i) state_d = SCHED_IDLE;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         acc_q <= '0;
         tag_q <= '0;
      end else if (clear_i) begin
         acc_q <= '0;
         tag_q <= '0;
      end else if (state_q == SCHED_LAUNCH) begin
         acc_q <= head_desc;
         tag_q <= head_tag;
      end
   end

   // During LAUNCH the head is shown directly so the new descriptor lines up
   // with acc_start_o; afterwards the registered copy holds it stable.
   assign acc_view       = (state_q == SCHED_LAUNCH) ? head_desc : acc_q;
   assign acc_in_addr_o  = ADDR_W'(acc_view.in_addr);
   assign acc_out_addr_o = ADDR_W'(acc_view.out_addr);
   assign acc_in_len_o   = LEN_W'(acc_view.in_len);
   assign acc_out_len_o  = LEN_W'(acc_view.out_len);
   assign busy_o         = (state_q != SCHED_IDLE) || !empty;

endmodule

// File: tb/tb_dummy_hls_ip_job_sched.sv
// tb_dummy_hls_ip_job_sched: scoreboard bench for the job scheduler.
module tb_dummy_hls_ip_job_sched;

   localparam int NB = 2;
   localparam int D  = 4;
   localparam int AW = 32;
   localparam int LW = 16;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic                   clear = 1'b0;
   logic                   done = 1'b0;
   logic [NB-1:0]          valid = '0;
   logic [NB-1:0]          ready, evt;
   logic [NB-1:0][AW-1:0]  req_in_addr = '0, req_out_addr = '0;
   logic [NB-1:0][LW-1:0]  req_in_len = '0, req_out_len = '0;
   logic                   start, busy;
   logic [AW-1:0]          acc_in_addr, acc_out_addr;
   logic [LW-1:0]          acc_in_len, acc_out_len;
   logic [$clog2(D+1)-1:0] occ;

   typedef struct {
      logic [AW-1:0] in_addr;
      logic [AW-1:0] out_addr;
      logic [LW-1:0] in_len;
      logic [LW-1:0] out_len;
      int            tag;
   } job_t;

   job_t exp_q[$];
   int   evt_q[$];
   int   n_cmp = 0, n_err = 0, seq = 0, exp_rr = 0, n_acc = 0;

   dummy_hls_ip_job_sched #(.NB_REQ(NB), .DEPTH(D), .ADDR_W(AW), .LEN_W(LW)) dut (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
      .req_valid_i(valid), .req_ready_o(ready),
      .req_in_addr_i(req_in_addr), .req_out_addr_i(req_out_addr),
      .req_in_len_i(req_in_len), .req_out_len_i(req_out_len),
      .acc_start_o(start), .acc_in_addr_o(acc_in_addr), .acc_out_addr_o(acc_out_addr),
      .acc_in_len_o(acc_in_len), .acc_out_len_o(acc_out_len),
      .acc_done_i(done), .evt_o(evt), .busy_o(busy), .occupancy_o(occ)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int r, input logic [LW-1:0] len);
      seq++;
      req_in_addr[r]  = 32'h1000_0000 + (seq << 4) + r;
      req_out_addr[r] = 32'h2000_0000 + seq;
      req_in_len[r]   = len;
      req_out_len[r]  = 16'h0100 + 16'(seq);
   endtask

   function automatic job_t snap(input int r);
      job_t j;
      j.in_addr  = req_in_addr[r];
      j.out_addr = req_out_addr[r];
      j.in_len   = req_in_len[r];
      j.out_len  = req_out_len[r];
      j.tag      = r;
      return j;
   endfunction

   // One accept from a single requester; returns one cycle after the accept edge.
   task automatic accept(input int r, input logic [LW-1:0] len);
      load(r, len);
      valid    = '0;
      valid[r] = 1'b1;
      #1;
      check("ready_single", ready, 64'(1) << r);
      exp_q.push_back(snap(r));
      exp_rr = (r + 1) % NB;
      step();
      valid = '0;
   endtask

   // Answer every launched job with a done pulse until the scheduler empties.
   task automatic drain();
      int budget = 300;
      while ((busy || exp_q.size() > 0 || evt_q.size() > 0) && budget > 0) begin
         if (evt_q.size() > 0 && !start) begin
            done = 1'b1;
            step();
            done = 1'b0;
            step();
            step();
            budget -= 3;
         end else begin
            step();
            budget--;
         end
      end
      check("drain_in_budget", 64'(budget > 0), 1);
      check("drain_idle", busy, 0);
   endtask

   // Scoreboard: starts pop the expected descriptor; events pop the issuing tag.
   always @(negedge clk) begin : mon
      job_t j;
      int   t;
      if (rst_n) begin
         if (start) begin
            if (exp_q.size() == 0) check("start_unexpected", start, 0);
            else begin
               j = exp_q.pop_front();
               check("start_in_addr", acc_in_addr, j.in_addr);
               check("start_out_addr", acc_out_addr, j.out_addr);
               check("start_in_len", acc_in_len, j.in_len);
               check("start_out_len", acc_out_len, j.out_len);
               evt_q.push_back(j.tag);
            end
         end
         if (evt != '0) begin
            if (evt_q.size() > 0) begin
               t = evt_q.pop_front();
               check("evt_tag", evt, 64'(1) << t);
            end else if (exp_q.size() > 0) begin
               j = exp_q.pop_front();
               check("zero_len_job", acc_in_len, 0);
               check("zero_len_addr", acc_in_addr, j.in_addr);
               check("zero_len_evt", evt, 64'(1) << j.tag);
            end else check("evt_unexpected", evt, 0);
         end
      end
   end

   initial begin
      repeat (3) step();
      check("rst_ready", ready, 0);
      check("rst_start", start, 0);
      check("rst_evt", evt, 0);
      check("rst_busy", busy, 0);
      check("rst_occ", occ, 0);
      check("rst_acc_in_addr", acc_in_addr, 0);
      check("rst_acc_out_len", acc_out_len, 0);
      rst_n = 1'b1;
      step();

      // Single job: start two cycles after accept, evt one cycle after done.
      accept(0, 16'd8);
      check("s1_no_start_k1", start, 0);
      check("s1_occ_k1", occ, 1);
      check("s1_busy_k1", busy, 1);
      step();
      check("s1_start_k2", start, 1);
      check("s1_in_len", acc_in_len, 8);
      step();
      check("s1_start_once", start, 0);
      step();
      check("s1_hold_addr", acc_in_addr, 32'h1000_0000 + (1 << 4));
      done = 1'b1;
      check("s1_evt_at_done", evt, 0);
      step();
      done = 1'b0;
      check("s1_evt_after_done", evt, 1);
      step();
      check("s1_evt_once", evt, 0);
      check("s1_idle", busy, 0);

      // Spurious done in IDLE.
      done = 1'b1;
      step();
      done = 1'b0;
      check("idle_done_evt", evt, 0);
      check("idle_done_busy", busy, 0);

      // Spurious done in LAUNCH.
      accept(0, 16'd5);
      step();
      check("launch_start", start, 1);
      done = 1'b1;
      step();
      done = 1'b0;
      check("launch_done_evt", evt, 0);
      step();
      step();
      check("launch_done_still_run", busy, 1);
      check("launch_done_no_evt", evt, 0);
      done = 1'b1;
      step();
      done = 1'b0;
      check("launch_real_evt", evt, 1);
      step();
      check("launch_idle", busy, 0);

      // Both requesters continuously valid: alternate grants until full.
      load(0, 16'h20);
      load(1, 16'h30);
      valid = 2'b11;
      n_acc = 0;
      for (int i = 0; i < 12; i++) begin
         #1;
         if (ready == '0) break;
         check("rr_grant", ready, 64'(1) << exp_rr);
         exp_q.push_back(snap(exp_rr));
         n_acc++;
         step();
         load(exp_rr, 16'h20 + 16'(n_acc));
         exp_rr = (exp_rr + 1) % NB;
      end
      check("fill_accepts", n_acc, 5);
      check("fill_occ", occ, 4);
      for (int i = 0; i < 3; i++) begin
         check("full_ready_low", ready, 0);
         step();
      end
      done = 1'b1;
      step();
      done = 1'b0;
      step();
      step();
      check("full_launch_ready", ready, 0);
      check("full_launch_start", start, 1);
      step();
      check("ready_back", ready, 64'(1) << exp_rr);
      check("ready_back_occ", occ, 3);
      valid = '0;
      drain();

      // Zero-length job from requester 1, then a normal job.
      accept(1, 16'd0);
      accept(0, 16'd4);
      check("zl_no_start_k2", start, 0);
      step();
      check("zl_evt", evt, 2);
      check("zl_no_start_k3", start, 0);
      step();
      check("zl_no_start_k4", start, 0);
      check("zl_evt_once", evt, 0);
      step();
      check("zl_next_start", start, 1);
      drain();

      // Flush during RUN with three jobs queued.
      for (int i = 0; i < 4; i++) accept(0, 16'h10 + 16'(i));
      check("clr_occ_before", occ, 3);
      clear = 1'b1;
      step();
      clear = 1'b0;
      exp_q.delete();
      evt_q.delete();
      check("clr_occ", occ, 0);
      check("clr_busy", busy, 0);
      check("clr_evt", evt, 0);
      check("clr_start", start, 0);
      check("clr_acc_addr", acc_in_addr, 0);
      valid = 2'b11;
      #1;
      check("clr_rr_reset", ready, 1);
      valid = '0;
      done = 1'b1;
      step();
      done = 1'b0;
      check("clr_late_done_evt", evt, 0);
      step();
      check("clr_late_done_evt2", evt, 0);
      check("clr_still_idle", busy, 0);
      accept(1, 16'd3);
      drain();

      // Asynchronous reset mid-RUN.
      accept(0, 16'd6);
      accept(1, 16'd7);
      step();
      check("ar_occ_before", occ, 1);
      #2 rst_n = 1'b0;
      #1;
      check("ar_start", start, 0);
      check("ar_busy", busy, 0);
      check("ar_occ", occ, 0);
      check("ar_evt", evt, 0);
      check("ar_acc_addr", acc_in_addr, 0);
      check("ar_ready", ready, 0);
      exp_q.delete();
      evt_q.delete();
      step();
      rst_n = 1'b1;
      step();
      done = 1'b1;
      step();
      done = 1'b0;
      check("ar_late_done_evt", evt, 0);
      step();
      check("ar_late_done_evt2", evt, 0);
      check("ar_idle", busy, 0);
      accept(0, 16'd2);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/dummy_hls_ip_job_sched.md
# dummy_hls_ip_job_sched

Job scheduler that shares one dummy HLS HWPE instance between several requesters (cores or DMA masters). It arbitrates round-robin among requester descriptor ports, queues accepted jobs in a small FIFO, and dispatches them one at a time to the accelerator control FSM with a start/done handshake. It sits between the requester-side register/event logic and the HWPE's control input, and routes each completion event back to the requester that issued the job.

## Interface
- NB_REQ, 2: number of requester ports (≥1)
- DEPTH, 4: job FIFO depth (power of two, ≥2)
- ADDR_W, 32: address width
- LEN_W, 16: length field width
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- clear_i  in  1  synchronous flush
- req_valid_i  in  NB_REQ  per-requester descriptor valid
- req_ready_o  out  NB_REQ  per-requester accept (one-hot or zero)
- req_in_addr_i  in  NB_REQ×ADDR_W  input stream base address
- req_out_addr_i  in  NB_REQ×ADDR_W  output stream base address
- req_in_len_i  in  NB_REQ×LEN_W  input stream length
- req_out_len_i  in  NB_REQ×LEN_W  output stream length
- acc_start_o  out  1  one-cycle start pulse to HWPE control
- acc_in_addr_o, acc_out_addr_o  out  ADDR_W  dispatched job addresses
- acc_in_len_o, acc_out_len_o  out  LEN_W  dispatched job lengths
- acc_done_i  in  1  one-cycle job-complete pulse from HWPE
- evt_o  out  NB_REQ  one-cycle completion pulse to the issuing requester
- busy_o  out  1  scheduler not idle or FIFO non-empty
- occupancy_o  out  $clog2(DEPTH+1)  FIFO entries

## Operation
- Arbitration: pointer rr_q (reset 0). Grant = first i with req_valid_i[i], searching from rr_q upward with wrap. req_ready_o[grant]=1 only if FIFO not full; combinational from valid and rr_q.
- On accept: push {descriptor, requester tag}; rr_q <= grant+1 mod NB_REQ. No accept → rr_q unchanged.
- Full: all req_ready_o low, even in a cycle where a pop occurs (ready uses current full).
- Dispatcher FSM:
  - IDLE: FIFO non-empty → LAUNCH.
  - LAUNCH: pop head, latch descriptor into acc_* registers and tag. If head in_len==0 → DONE (no start). Else acc_start_o=1 this cycle, → RUN.
  - RUN: acc_done_i → DONE.
  - DONE: evt_o[tag]=1, → IDLE.
- acc_done_i outside RUN is ignored.
- Descriptor values: acc_* are registered and stable from the LAUNCH edge until the next LAUNCH.
- clear_i: FIFO emptied, FSM → IDLE, rr_q → 0, acc_* → 0; no evt_o for flushed or in-flight jobs. The HWPE must be cleared by the same signal.

## Timing
- Reset values: req_ready_o per arbitration rule (0 when no valid), acc_start_o 0, acc_* 0, evt_o 0, busy_o 0, occupancy_o 0.
- Accept at edge k → occupancy visible k+1 → FSM in LAUNCH at k+2 with acc_start_o high. Minimum accept-to-start latency is 2 cycles.
- acc_start_o and acc_* new values appear in the same cycle. acc_* come from the FIFO head combinationally in LAUNCH and are registered at the end of that cycle.
- acc_done_i at cycle d → evt_o at d+1 → IDLE at d+2.
- Back-to-back jobs: at least 3 cycles from done pulse to next start.
- Zero-length job: accept → evt_o 3 cycles later, acc_start_o never asserted.
- Simultaneous push and pop in LAUNCH: occupancy unchanged.

## Structure
- Package dummy_hls_ip_sched_package contains:
  - job_desc_t struct (in_addr, out_addr, in_len, out_len)
  - sched_state_t enum (SCHED_IDLE, SCHED_LAUNCH, SCHED_RUN, SCHED_DONE)
  - Default parameter constants
- Sub-module dummy_hls_ip_job_fifo: synchronous FIFO of {job_desc_t, tag}, with DEPTH entries, push/pop/clear, full/empty/count, and fall-through head.
- Arbiter and FSM live in the top module.

## Test plan
- Single job, requester 0 (in_len 8): acc_start_o 2 cycles after accept; acc_done_i at t → evt_o[0] at t+1 only.
- Both requesters valid continuously, NB_REQ=2: grants alternate 0,1,0,1 until full. occupancy_o=4, all ready low; after one done/pop, ready reappears.
- Zero-length job from requester 1: evt_o[1] pulses, acc_start_o stays 0, next queued job then launches normally.
- Spurious acc_done_i in IDLE/LAUNCH: no evt_o, no state change.
- clear_i during RUN with 3 queued jobs: next cycle occupancy_o=0, busy_o=0, no evt_o, then a new job dispatches normally.
- Async reset mid-RUN: all outputs at reset values immediately. A late acc_done_i after release produces no evt_o.
